// File: rtl/senha_pkg.sv
// Shared types and display constants for the keypad code sequencer.
package senha_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_ENTRY,
    ST_SHIFT,
    ST_VERDICT,
    ST_OPEN,
    ST_LOCK
  } state_t;

  // Segment order {A,B,C,D,E,F,G}, bit 6 = A, active-high.
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_U    = 7'b0111110;
  localparam logic [6:0] SEG_L    = 7'b0001110;

  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

endpackage

// File: rtl/seg7_decoder.sv
// BCD to 7-segment decoder; non-decimal codes show a dash.
module seg7_decoder
  import senha_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup with a dash fallback for codes above 9.
  always_comb begin
    seg = SEG_DASH;
    if (bcd <= 4'd9) seg = SEG_DIGITS[bcd];
  end

endmodule

// File: rtl/sequenciador_senha.sv
// Keypad front-end for the serial code checker: accepts digits, serialises
// them MSB-first, collects the verdict, counts failures and enforces lockout.
module sequenciador_senha
  import senha_pkg::*;
#(
  parameter int unsigned DIGITS          = 6,
  parameter int unsigned MAX_FAIL        = 3,
  parameter int unsigned LOCK_CYCLES     = 1000,
  parameter int unsigned UNLOCK_CYCLES   = 500,
  parameter int unsigned VERDICT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dig_valid,
  input  logic [3:0] dig_data,
  output logic       dig_ready,
  input  logic       cancela,
  output logic       ser_insere,
  output logic       ser_numero,
  output logic       chk_reset,
  input  logic       chk_ok,
  input  logic       chk_fail,
  output logic       unlocked,
  output logic       locked_out,
  output logic [6:0] seg
);

  localparam int unsigned DCW    = $clog2(DIGITS + 1);
  localparam int unsigned FCW    = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMAX_A = (LOCK_CYCLES > UNLOCK_CYCLES) ? LOCK_CYCLES : UNLOCK_CYCLES;
  localparam int unsigned TMAX   = (TMAX_A > VERDICT_TIMEOUT) ? TMAX_A : VERDICT_TIMEOUT;
  localparam int unsigned TW     = $clog2(TMAX + 1);

  localparam logic [DCW-1:0] DIG_LAST  = DCW'(DIGITS);
  localparam logic [FCW-1:0] FAIL_LAST = FCW'(MAX_FAIL);
  localparam logic [TW-1:0]  T_OPEN    = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0]  T_LOCK    = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0]  T_VERD    = TW'(VERDICT_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [3:0]     shreg_q, shreg_d;
  logic [3:0]     digit_q, digit_d;
  logic [1:0]     bit_cnt_q, bit_cnt_d;
  logic [DCW-1:0] dig_cnt_q, dig_cnt_d;
  logic [FCW-1:0] fail_cnt_q, fail_cnt_d;
  logic [TW-1:0]  timer_q, timer_d;

  logic [DCW-1:0] dig_cnt_inc;
  logic [FCW-1:0] fail_cnt_inc;
  logic [6:0]     digit_seg;

  // digit_q holds 4'hF when no digit has been shown yet, so the decoder's
  // dash fallback doubles as the "no digit" display.
  seg7_decoder u_seg7 (
    .bcd (digit_q),
    .seg (digit_seg)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_CLEAR;
      shreg_q    <= '0;
      digit_q    <= '1;
      bit_cnt_q  <= '0;
      dig_cnt_q  <= '0;
      fail_cnt_q <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      digit_q    <= digit_d;
      bit_cnt_q  <= bit_cnt_d;
      dig_cnt_q  <= dig_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      timer_q    <= timer_d;
    end
  end

  // Next-state, datapath updates and Moore control outputs.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    digit_d      = digit_q;
    bit_cnt_d    = bit_cnt_q;
    dig_cnt_d    = dig_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    dig_ready    = 1'b0;
    ser_insere   = 1'b0;
    ser_numero   = 1'b0;
    chk_reset    = 1'b0;
    unlocked     = 1'b0;
    locked_out   = 1'b0;
    dig_cnt_inc  = dig_cnt_q + DCW'(1);
    fail_cnt_inc = fail_cnt_q + FCW'(1);

    case (state_q)
      ST_CLEAR: begin
        chk_reset = 1'b1;
        dig_cnt_d = '0;
        shreg_d   = '0;
        bit_cnt_d = '0;
        digit_d   = '1;
        state_d   = ST_ENTRY;
      end
      ST_ENTRY: begin
        dig_ready = 1'b1;
        if (cancela) begin
          state_d = ST_CLEAR;
        end else if (dig_valid && dig_data <= 4'd9) begin
          digit_d   = dig_data;
          shreg_d   = dig_data;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ser_insere = 1'b1;
        ser_numero = shreg_q[3];
        if (cancela) begin
          state_d = ST_CLEAR;
        end else begin
          shreg_d   = {shreg_q[2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 2'd1;
          if (bit_cnt_q == 2'd3) begin
            dig_cnt_d = dig_cnt_inc;
            if (dig_cnt_inc == DIG_LAST) begin
              timer_d = T_VERD;
              state_d = ST_VERDICT;
            end else begin
              state_d = ST_ENTRY;
            end
          end
        end
      end
      ST_VERDICT: begin
        // A real verdict in the last waiting cycle beats the timeout.
        if (cancela) begin
          state_d = ST_CLEAR;
        end else if (chk_fail || (!chk_ok && timer_q == '0)) begin
          if (fail_cnt_inc == FAIL_LAST) begin
            fail_cnt_d = '0;
            timer_d    = T_LOCK;
            state_d    = ST_LOCK;
          end else begin
            fail_cnt_d = fail_cnt_inc;
            state_d    = ST_CLEAR;
          end
        end else if (chk_ok) begin
          fail_cnt_d = '0;
          timer_d    = T_OPEN;
          state_d    = ST_OPEN;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_OPEN: begin
        unlocked = 1'b1;
        if (timer_q == '0) state_d = ST_CLEAR;
        else               timer_d = timer_q - TW'(1);
      end
      ST_LOCK: begin
        locked_out = 1'b1;
        if (timer_q == '0) state_d = ST_CLEAR;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Status display selection.
  always_comb begin
    seg = SEG_DASH;
    case (state_q)
      ST_ENTRY, ST_SHIFT, ST_VERDICT: seg = digit_seg;
      ST_OPEN:                        seg = SEG_U;
      ST_LOCK:                        seg = SEG_L;
      default:                        seg = SEG_DASH;
    endcase
  end

endmodule
